// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic matrix-multiply core: FSM encoding,
// default geometry and the lane-slicing convention (lane 0 sits at the MSB end).
package tpu_pkg;

    localparam int N_DEF  = 16;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 32;
    localparam int KW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // LSB position of lane 'lane' in a bus of n lanes, each w bits wide.
    function automatic int lane_lsb(input int lane, input int n, input int w);
        return w * (n - 1 - lane);
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// Output-stationary processing element: forwards a right and b down, and
// accumulates the sign/zero-extended product (wrapping) on every advance.
module tpu_pe #(
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          sgn,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic [AW-1:0] acc
);

    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] a_ext;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] prod;

    // Extending both operands to AW before multiplying gives the correct
    // two's-complement product modulo 2^AW for signed and unsigned alike.
    always_comb begin
        a_ext = {{(AW-DW){sgn & a_in[DW-1]}}, a_in};
        b_ext = {{(AW-DW){sgn & b_in[DW-1]}}, b_in};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc_q <= acc_q + prod;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/tpu_sa_core.sv
// N x N output-stationary systolic matmul core with runtime K, valid/ready
// streams, whole-array stall on input bubbles and optional cross-job accumulation.
module tpu_sa_core
    import tpu_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int KW = KW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KW-1:0]        cfg_k,
    input  logic                 cfg_acc,
    input  logic                 cfg_signed,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      mat_di,
    input  logic [N*DW-1:0]      wei_di,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*AW-1:0]      out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic                 out_last,
    output logic                 done
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q;
    logic          sgn_q;
    logic [KW-1:0] beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [RW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          adv;
    logic          clr;

    logic [DW-1:0] a_edge [N];
    logic [DW-1:0] b_edge [N];
    logic [DW-1:0] a_fwd  [N][N];
    logic [DW-1:0] b_fwd  [N][N];
    logic [AW-1:0] acc_w  [N][N];

    // Every skew stage and PE moves together; an input bubble freezes the lot.
    assign adv = ((state_q == ST_FEED) && in_valid) || (state_q == ST_FLUSH);
    assign clr = (state_q == ST_IDLE) && start && !cfg_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            sgn_q   <= 1'b0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
            if ((state_q == ST_IDLE) && start) begin
                k_q   <= cfg_k;
                sgn_q <= cfg_signed;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        row_d     = row_q;
        done_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    beat_d  = '0;
                    flush_d = '0;
                    row_d   = '0;
                    state_d = (cfg_k != '0) ? ST_FEED : ST_DRAIN;
                end
            end
            ST_FEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q + KW'(1) == k_q) begin
                        flush_d = '0;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(2 * N - 2)) begin
                    row_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    row_d = row_q + RW'(1);
                    if (row_q == RW'(N - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane i is delayed i stages so operands meet their partners diagonally.
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DW-1:0] a_src;
        logic [DW-1:0] b_src;
        assign a_src = (state_q == ST_FEED) ? mat_di[lane_lsb(gi, N, DW) +: DW] : '0;
        assign b_src = (state_q == ST_FEED) ? wei_di[lane_lsb(gi, N, DW) +: DW] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_src;
            assign b_edge[gi] = b_src;
        end else begin : g_dly
            logic [DW-1:0] a_sk_q [gi];
            logic [DW-1:0] b_sk_q [gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        a_sk_q[s] <= '0;
                        b_sk_q[s] <= '0;
                    end
                end else if (adv) begin
                    a_sk_q[0] <= a_src;
                    b_sk_q[0] <= b_src;
                    for (int s = 1; s < gi; s++) begin
                        a_sk_q[s] <= a_sk_q[s-1];
                        b_sk_q[s] <= b_sk_q[s-1];
                    end
                end
            end
            assign a_edge[gi] = a_sk_q[gi-1];
            assign b_edge[gi] = b_sk_q[gi-1];
        end
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            logic [DW-1:0] a_in_w;
            logic [DW-1:0] b_in_w;
            if (gc == 0) begin : g_a_edge
                assign a_in_w = a_edge[gr];
            end else begin : g_a_pe
                assign a_in_w = a_fwd[gr][gc-1];
            end
            if (gr == 0) begin : g_b_edge
                assign b_in_w = b_edge[gc];
            end else begin : g_b_pe
                assign b_in_w = b_fwd[gr-1][gc];
            end
            tpu_pe #(.DW(DW), .AW(AW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (adv),
                .clr   (clr),
                .sgn   (sgn_q),
                .a_in  (a_in_w),
                .b_in  (b_in_w),
                .a_out (a_fwd[gr][gc]),
                .b_out (b_fwd[gr][gc]),
                .acc   (acc_w[gr][gc])
            );
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == ST_DRAIN) begin
            for (int c = 0; c < N; c++) begin
                out_data[lane_lsb(c, N, AW) +: AW] = acc_w[row_q][c];
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign out_row  = row_q;
    assign out_last = (state_q == ST_DRAIN) && (row_q == RW'(N - 1));
    assign done     = done_q;

endmodule

// File: tb/tb_tpu_sa_core.sv
// Directed and randomised jobs against a 16x16 core; expected rows come from
// hand-computed constants or a small reference matmul.
module tb_tpu_sa_core;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int KW = 16;
    localparam int CW = N * AW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   cfg_k;
    logic            cfg_acc;
    logic            cfg_signed;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] mat_di;
    logic [N*DW-1:0] wei_di;
    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_data;
    logic [3:0]      out_row;
    logic            out_last;
    logic            done;

    tpu_sa_core #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_k      (cfg_k),
        .cfg_acc    (cfg_acc),
        .cfg_signed (cfg_signed),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mat_di     (mat_di),
        .wei_di     (wei_di),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_last   (out_last),
        .done       (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] a_v [N][N];
    logic [DW-1:0] b_v [N][N];
    logic [AW-1:0] model [N][N];
    logic [CW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] v, input logic s);
        return s ? {{(AW-DW){v[DW-1]}}, v} : {{(AW-DW){1'b0}}, v};
    endfunction

    task automatic set_ops_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_v[k][i] = a;
                b_v[k][i] = b;
            end
    endtask

    task automatic set_ops_rand();
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) begin
                a_v[k][i] = DW'($urandom_range(255, 0));
                b_v[k][i] = DW'($urandom_range(255, 0));
            end
    endtask

    task automatic fill_const(input logic [AW-1:0] v);
        logic [CW-1:0] row;
        exp_q.delete();
        for (int c = 0; c < N; c++) row[AW*(N-1-c) +: AW] = v;
        for (int r = 0; r < N; r++) exp_q.push_back(row);
    endtask

    task automatic fill_model(input int k, input bit s);
        logic [CW-1:0] row;
        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                model[r][c] = '0;
                for (int kk = 0; kk < k; kk++)
                    model[r][c] = model[r][c] + ext(a_v[kk][r], s) * ext(b_v[kk][c], s);
            end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row[AW*(N-1-c) +: AW] = model[r][c];
            exp_q.push_back(row);
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            mat_di[DW*(N-1-i) +: DW] = a_v[k][i];
            wei_di[DW*(N-1-i) +: DW] = b_v[k][i];
        end
    endtask

    // Runs one job with the given gap/stall percentages and drains it against exp_q.
    task automatic run_job(input int k, input bit acc, input bit s, input int gap_pct,
                           input int stall_pct, input bit extra_start, input int exp_lat);
        int cyc, beat, rows, first_ov;
        bit prev_stall;
        logic [CW-1:0] exp_row, held_data;
        logic [3:0] held_row;
        logic held_last;
        @(negedge clk);
        cfg_k = KW'(k); cfg_acc = acc; cfg_signed = s; start = 1'b1;
        cyc = 0; beat = 0; rows = 0; first_ov = -1; prev_stall = 1'b0;
        held_data = '0; held_row = '0; held_last = 1'b0;
        while (rows < N && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (cyc == 1) check("busy_after_start", CW'(busy), CW'(1));
            if (extra_start && cyc == 3) begin
                start = 1'b1;
                cfg_k = KW'(7);
            end
            in_valid = 1'b0;
            if (in_ready && beat < k && $urandom_range(99, 0) >= gap_pct) begin
                drive_beat(beat);
                in_valid = 1'b1;
                beat++;
            end
            out_ready = 1'b0;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                check("in_ready_in_drain", CW'(in_ready), CW'(0));
                if (prev_stall) begin
                    check("stall_data", out_data, held_data);
                    check("stall_row", CW'(out_row), CW'(held_row));
                    check("stall_last", CW'(out_last), CW'(held_last));
                end
                out_ready = ($urandom_range(99, 0) >= stall_pct);
                if (out_ready) begin
                    exp_row = exp_q.pop_front();
                    check("row_data", out_data, exp_row);
                    check("row_index", CW'(out_row), CW'(rows));
                    check("row_last", CW'(out_last), CW'(rows == N - 1));
                    rows++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    held_data = out_data;
                    held_row = out_row;
                    held_last = out_last;
                end
            end
        end
        check("rows_drained", CW'(rows), CW'(N));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("done_pulse", CW'(done), CW'(1));
        check("busy_idle", CW'(busy), CW'(0));
        @(negedge clk);
        check("done_cleared", CW'(done), CW'(0));
        if (exp_lat > 0) check("first_out_latency", CW'(first_ov), CW'(exp_lat));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_acc = 1'b0; cfg_signed = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; mat_di = '0; wei_di = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_in_ready", CW'(in_ready), CW'(0));
        check("rst_out_valid", CW'(out_valid), CW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_row", CW'(out_row), CW'(0));
        check("rst_out_last", CW'(out_last), CW'(0));
        check("rst_done", CW'(done), CW'(0));

        // 1*2 summed over 16 beats, no bubbles: 48-cycle latency.
        set_ops_const(8'd1, 8'd2);
        fill_const(32'd32);
        run_job(16, 1'b0, 1'b0, 0, 0, 1'b0, 48);

        // 0xFF * 3 over 4 beats: -12 signed, 3060 unsigned.
        set_ops_const(8'hFF, 8'd3);
        fill_const(32'hFFFF_FFF4);
        run_job(4, 1'b0, 1'b1, 0, 0, 1'b0, 0);
        fill_const(32'd3060);
        run_job(4, 1'b0, 1'b0, 0, 0, 1'b0, 0);

        // Accumulate across jobs, then clear again.
        set_ops_const(8'd1, 8'd1);
        fill_const(32'd2);
        run_job(2, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        fill_const(32'd4);
        run_job(2, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        fill_const(32'd2);
        run_job(2, 1'b0, 1'b0, 0, 0, 1'b0, 0);

        // Random operands with input bubbles and output stalls.
        set_ops_rand();
        fill_model(16, 1'b1);
        run_job(16, 1'b0, 1'b1, 30, 40, 1'b0, 0);
        set_ops_rand();
        fill_model(16, 1'b0);
        run_job(16, 1'b0, 1'b0, 40, 30, 1'b1, 0);

        // K=0 drains zeros straight away; a start pulse while busy is ignored.
        fill_const(32'd0);
        run_job(0, 1'b0, 1'b0, 0, 30, 1'b1, 0);

        // Reset after 5 beats of a job, then a clean job must show no residue.
        set_ops_const(8'd7, 8'd9);
        @(negedge clk);
        cfg_k = KW'(16); cfg_acc = 1'b0; cfg_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            drive_beat(b);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", CW'(busy), CW'(0));
        check("midrst_in_ready", CW'(in_ready), CW'(0));
        check("midrst_out_valid", CW'(out_valid), CW'(0));
        set_ops_const(8'd1, 8'd2);
        fill_const(32'd32);
        run_job(16, 1'b1, 1'b0, 0, 0, 1'b0, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_sa_core.md
Name: tpu_sa_core

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply core. Successor to the fixed 16x16 TPU wrapper.
- Adds runtime reduction length K, valid/ready handshakes on input and output, whole-array stall on input bubbles, signed/unsigned mode, and optional accumulation across jobs.
- Sits between the host-side DMA streams (operand beats in) and the result writeback stream (one result row per beat out).

Parameters:
N, 16, array dimension (rows = columns = operand lanes); must be >= 2
DW, 8, operand lane width in bits
AW, 32, accumulator / result lane width in bits
KW, 16, width of the runtime reduction-length field

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
cfg_k  in  KW  reduction length K (operand beats per job); latched on accepted start
cfg_acc  in  1  1 = keep accumulators from previous job; 0 = clear at start; latched
cfg_signed  in  1  1 = operands are two's complement; 0 = unsigned; latched
busy  out  1  high in every state except IDLE
in_valid  in  1  operand beat valid
in_ready  out  1  core accepts a beat; high only in FEED
mat_di  in  N*DW  A column k; lane i (row i) at [DW*(N-1-i) +: DW]
wei_di  in  N*DW  B row k; lane j (column j) at [DW*(N-1-j) +: DW]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts the row
out_data  out  N*AW  C row r; lane j at [AW*(N-1-j) +: AW]
out_row  out  $clog2(N)  index r of the current row
out_last  out  1  high with the row r = N-1
done  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-job): state goes to IDLE. All accumulators, skew registers and latched cfg are cleared. The beat and row counters are cleared.
- Outputs after reset: busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0.
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - start=1 latches cfg_k, cfg_acc and cfg_signed.
  - Accumulators are cleared on this edge if cfg_acc=0.
  - Next state is FEED if cfg_k != 0, otherwise DRAIN (rows come out as they stand: zeros, or the retained sums).
  - start outside IDLE is ignored.
- FEED:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - Accepted beat: lane i of A enters a skew delay of i stages; lane j of B enters a skew delay of j stages. The whole array (skew registers plus PEs) advances one step.
  - No beat (in_valid=0): the whole array holds, with no shift and no accumulate.
  - After the K-th accepted beat, next state is FLUSH.
- FLUSH:
  - in_ready=0. Zeros are injected and the array advances every cycle for exactly 2N-1 cycles.
  - Then next state is DRAIN with r=0.
- PE(r,c), on each advance:
  - acc += a*b, where a is the operand from the left and b is the operand from the top.
  - a is forwarded right, b is forwarded down.
  - The product is sign- or zero-extended per the latched cfg_signed, to AW bits.
  - Accumulation wraps modulo 2^AW; no saturation.
- DRAIN:
  - out_valid=1; out_data holds the accumulators of row r; out_row=r; out_last=(r==N-1).
  - out_valid && !out_ready: out_data, out_row and out_last stay stable.
  - On handshake: r increments.
  - On handshake with r=N-1: next state is IDLE, and done=1 for exactly one cycle in the following cycle (IDLE).
- Accumulators are not modified in DRAIN, so a following cfg_acc=1 job continues from them.
- Minimum job latency: start edge to first out_valid = 1 + K + (2N-1) cycles, when in_valid is held high.
- start asserted in the same cycle as done: accepted, because the state is IDLE.

Decomposition:
- Shared package tpu_pkg holds:
  - the FSM state encoding (IDLE/FEED/FLUSH/DRAIN);
  - the lane-slicing convention (lane 0 at the MSB end);
  - the defaults N=16, DW=8, AW=32, KW=16.
- One sub-module, tpu_pe:
  - ports clk, rst, en, clr, sgn, a_in, b_in, a_out, b_out, acc;
  - instantiated N*N times by generate loops.
- Skew delay lines and the FSM stay in tpu_sa_core.

Test Plan:
- All A lanes=1, all B lanes=2, K=16, unsigned, cfg_acc=0, in_valid held high -> 16 rows, every lane 32. First out_valid 48 cycles after the start edge; out_last on row 15; done one cycle after the final handshake.
- A lanes=8'hFF, B lanes=3, K=4 -> with cfg_signed=1 every lane 32'hFFFFFFF4 (-12); with cfg_signed=0 every lane 3060.
- Job 1: A=1, B=1, K=2, cfg_acc=0 -> lanes 2. Job 2: same operands with cfg_acc=1 -> lanes 4. Job 3: same operands with cfg_acc=0 -> lanes 2.
- Random lane values, K=16, random in_valid gaps and random out_ready stalls -> results match the golden C=A*B bit-exactly. out_data, out_row and out_last stay unchanged during every stalled cycle; in_ready=0 outside FEED.
- cfg_k=0 after a cleared job -> immediate DRAIN of 16 all-zero rows. A second start pulsed while busy -> no effect on the results or on the row count.
- rst=1 for one cycle mid-FEED (after 5 beats) -> next cycle busy=0, in_ready=0, out_valid=0. A fresh K=16 job with A=1, B=2 then yields lanes 32 (no residue from the aborted job).
